// File: rtl/bcd_scan_display.sv
// Iterative binary-to-BCD converter feeding a time-multiplexed common-anode display.
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking of the upper digits.
module bcd_scan_display #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  done,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  // Enough digits that the shift-add-3 accumulator never truncates a DATA_W-bit value.
  localparam int BCD_DIGITS = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                      state_q, state_d;
  logic [DATA_W-1:0]           shreg_q, shreg_d;
  logic [4*BCD_DIGITS-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]     disp_q, disp_d;
  logic                        disp_valid_q, disp_valid_d;
  logic                        ovf_q, ovf_d;
  logic                        done_q, done_d;
  logic [PRE_W-1:0]            presc_q, presc_d;
  logic [IDX_W-1:0]            scan_idx_q, scan_idx_d;
  logic [6:0]                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;

  logic [4*EXT_DIGITS-1:0]     bcd_ext;
  logic                        upper_nz;
  logic [3:0]                  cur_digit;
  logic [NUM_DIGITS-1:0]       blank_vec;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  assign bcd_ext  = (4*EXT_DIGITS)'(bcd_q);
  assign upper_nz = |(bcd_ext >> (4 * NUM_DIGITS));

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    bcd_adj      = bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = LOAD;
      end
      LOAD: begin
        disp_d       = bcd_ext[4*NUM_DIGITS-1:0];
        disp_valid_d = 1'b1;
        ovf_d        = upper_nz;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_SCAN_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic seen_nz;
    seen_nz   = 1'b0;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz      = seen_nz | (disp_q[4*i +: 4] != 4'd0);
      blank_vec[i] = ~seen_nz;
    end
  end
`else
  assign blank_vec = '0;
`endif

  assign cur_digit = disp_q[4*scan_idx_q +: 4];

  always_comb begin
    presc_d    = presc_q + PRE_W'(1);
    scan_idx_d = scan_idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d    = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (disp_valid_q) begin
      an_d = ~(NUM_DIGITS'(1) << scan_idx_q);
      if (ovf_q)                      seg_d = SEG_DASH;
      else if (blank_vec[scan_idx_q]) seg_d = SEG_BLANK;
      else                            seg_d = seg_of(cur_digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      presc_q      <= '0;
      scan_idx_q   <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      presc_q      <= presc_d;
      scan_idx_q   <= scan_idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: a 3-digit instance (a) and a 2-digit instance (b),
// both with a short scan period so every digit can be observed quickly.
module tb_bcd_scan_display;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                         S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111,
                         S8 = 7'b0000000, S9 = 7'b0000100, SB = 7'b1111111, SD = 7'b1111110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data_a = '0, in_data_b = '0;
  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic       in_ready_a, in_ready_b, done_a, done_b, ovf_a, ovf_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] an_a;
  logic [1:0] an_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seen_a [3];
  logic [6:0] seen_b [2];
  logic [6:0] exp_a  [3];
  logic [6:0] exp_b  [2];

  always #5 clk = ~clk;

  bcd_scan_display #(.DATA_W(8), .NUM_DIGITS(3), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .done(done_a), .ovf(ovf_a), .seg(seg_a), .an(an_a));

  bcd_scan_display #(.DATA_W(8), .NUM_DIGITS(2), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .done(done_b), .ovf(ovf_b), .seg(seg_b), .an(an_b));

  // Issue one value to instance a or b and wait (bounded) for its done pulse.
  task automatic send(input bit to_b, input logic [7:0] v);
    int waited;
    waited = 0;
    while ((to_b ? in_ready_b : in_ready_a) !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    @(negedge clk);
    if (to_b) begin in_data_b = v; in_valid_b = 1'b1; end
    else      begin in_data_a = v; in_valid_a = 1'b1; end
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    waited = 0;
    while ((to_b ? done_b : done_a) !== 1'b1 && waited < 30) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (waited >= 30) begin
      n_fail++;
      $display("FAIL send_done_timeout inst=%0d value=%0d: no done pulse within 30 cycles", to_b, v);
    end else
      $display("send inst=%0d value=%0d done after %0d cycles", to_b, v, waited + 1);
  endtask

  task automatic capture();
    for (int d = 0; d < 3; d++) seen_a[d] = 'x;
    for (int d = 0; d < 2; d++) seen_b[d] = 'x;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      case (an_a)
        3'b110: seen_a[0] = seg_a;
        3'b101: seen_a[1] = seg_a;
        3'b011: seen_a[2] = seg_a;
        default: ;
      endcase
      case (an_b)
        2'b10: seen_b[0] = seg_b;
        2'b01: seen_b[1] = seg_b;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({in_ready_a, done_a, ovf_a, seg_a, an_a} !== {1'b1, 1'b0, 1'b0, SB, 3'b111}) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b done=%b ovf=%b seg=%b an=%b want 1 0 0 1111111 111",
               in_ready_a, done_a, ovf_a, seg_a, an_a);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if ({seg_a, an_a, seg_b, an_b} !== {SB, 3'b111, SB, 2'b11}) begin
      n_fail++;
      $display("FAIL idle_blank got seg=%b an=%b segb=%b anb=%b want all ones", seg_a, an_a, seg_b, an_b);
    end
  endtask

  // Value 255: done exactly one cycle after edge k+9, then digits 2,5,5.
  task automatic test_convert_255();
    @(negedge clk); in_data_a = 8'd255; in_valid_a = 1'b1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done_a !== (i == 9) || in_ready_a !== (i >= 9)) begin
        n_fail++;
        $display("FAIL latency_255 edge k+%0d got done=%b ready=%b want done=%b ready=%b",
                 i, done_a, in_ready_a, (i == 9), (i >= 9));
      end
    end
    $display("send inst=0 value=255 latency checked");
    capture();
    exp_a[0] = S5; exp_a[1] = S5; exp_a[2] = S2;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (seen_a[d] !== exp_a[d]) begin
        n_fail++;
        $display("FAIL digits_255 digit %0d got %b want %b", d, seen_a[d], exp_a[d]);
      end
    end
    n_checks++;
    if (ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_255 got %b want 0", ovf_a);
    end
  endtask

  task automatic test_scan();
    logic [2:0] prev, v0, want;
    int waited, idx0;
    prev = an_a; waited = 0;
    @(posedge clk); #1;
    while (an_a === prev && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    v0 = an_a;
    case (v0)
      3'b110:  idx0 = 0;
      3'b101:  idx0 = 1;
      3'b011:  idx0 = 2;
      default: idx0 = -1;
    endcase
    n_checks++;
    if (idx0 < 0 || waited >= 20) begin
      n_fail++;
      $display("FAIL scan_start got an=%b want a one-hot-low value", v0);
    end else begin
      for (int j = 0; j < 12; j++) begin
        want = ~(3'b001 << ((idx0 + j / 4) % 3));
        n_checks++;
        if (an_a !== want) begin
          n_fail++;
          $display("FAIL scan_seq cycle %0d got an=%b want %b", j, an_a, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_leading_zero();
    send(1'b0, 8'd7);
    capture();
`ifdef BCD_SCAN_LZB_EN
    exp_a[0] = S7; exp_a[1] = SB; exp_a[2] = SB;
`else
    exp_a[0] = S7; exp_a[1] = S0; exp_a[2] = S0;
`endif
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (seen_a[d] !== exp_a[d]) begin
        n_fail++;
        $display("FAIL digits_7 digit %0d got %b want %b", d, seen_a[d], exp_a[d]);
      end
    end
    send(1'b0, 8'd0);
    capture();
`ifdef BCD_SCAN_LZB_EN
    exp_a[0] = S0; exp_a[1] = SB; exp_a[2] = SB;
`else
    exp_a[0] = S0; exp_a[1] = S0; exp_a[2] = S0;
`endif
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (seen_a[d] !== exp_a[d]) begin
        n_fail++;
        $display("FAIL digits_0 digit %0d got %b want %b", d, seen_a[d], exp_a[d]);
      end
    end
  endtask

  task automatic test_overflow();
    send(1'b1, 8'd150);
    capture();
    n_checks++;
    if (ovf_b !== 1'b1 || seen_b[0] !== SD || seen_b[1] !== SD) begin
      n_fail++;
      $display("FAIL ovf_150 got ovf=%b d0=%b d1=%b want 1 1111110 1111110", ovf_b, seen_b[0], seen_b[1]);
    end
    send(1'b1, 8'd42);
    capture();
    exp_b[0] = S2; exp_b[1] = S4;
    n_checks++;
    if (ovf_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_42 got %b want 0", ovf_b);
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (seen_b[d] !== exp_b[d]) begin
        n_fail++;
        $display("FAIL digits_42 digit %0d got %b want %b", d, seen_b[d], exp_b[d]);
      end
    end
  endtask

  // 99 is presented throughout the 255 conversion and must only be taken at edge k+10.
  task automatic test_back_to_back();
    @(negedge clk); in_data_a = 8'd255; in_valid_a = 1'b1;
    @(posedge clk); #1; in_data_a = 8'd99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 10) in_valid_a = 1'b0;
      n_checks++;
      if (done_a !== (i == 9 || i == 19) || in_ready_a !== (i == 9 || i >= 19)) begin
        n_fail++;
        $display("FAIL b2b_timing edge k+%0d got done=%b ready=%b want done=%b ready=%b",
                 i, done_a, in_ready_a, (i == 9 || i == 19), (i == 9 || i >= 19));
      end
      if (i == 11) begin
        n_checks++;
        if (seg_a !== S2 && seg_a !== S5) begin
          n_fail++;
          $display("FAIL b2b_shows_255 got seg=%b an=%b want 0010010 or 0100100", seg_a, an_a);
        end
      end
    end
    $display("send inst=0 values=255,99 back to back");
    capture();
`ifdef BCD_SCAN_LZB_EN
    exp_a[0] = S9; exp_a[1] = S9; exp_a[2] = SB;
`else
    exp_a[0] = S9; exp_a[1] = S9; exp_a[2] = S0;
`endif
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (seen_a[d] !== exp_a[d]) begin
        n_fail++;
        $display("FAIL digits_99 digit %0d got %b want %b", d, seen_a[d], exp_a[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); in_data_a = 8'd200; in_valid_a = 1'b1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_a, done_a, seg_a, an_a} !== {1'b1, 1'b0, SB, 3'b111}) begin
      n_fail++;
      $display("FAIL async_reset got ready=%b done=%b seg=%b an=%b want 1 0 1111111 111",
               in_ready_a, done_a, seg_a, an_a);
    end
    @(negedge clk); rst_n = 1'b1;
    send(1'b0, 8'd9);
    capture();
`ifdef BCD_SCAN_LZB_EN
    exp_a[0] = S9; exp_a[1] = SB; exp_a[2] = SB;
`else
    exp_a[0] = S9; exp_a[1] = S0; exp_a[2] = S0;
`endif
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (seen_a[d] !== exp_a[d]) begin
        n_fail++;
        $display("FAIL digits_9 digit %0d got %b want %b", d, seen_a[d], exp_a[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert_255();
    test_scan();
    test_leading_zero();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Parametrised successor to the combinational 4-bit two-digit seven-segment decoder.
- Accepts a DATA_W-bit binary value through a valid/ready handshake and converts it to BCD iteratively (shift-add-3, one bit per cycle).
- Latches the resulting digits and time-multiplexes NUM_DIGITS common-anode displays via a scan prescaler.
- Drives the traffic-light countdown/status display.

Parameters:
- DATA_W, 8, binary input width (>=4).
- NUM_DIGITS, 3, number of physical digits scanned (1..8).
- SCAN_DIV, 50000, clk cycles each digit stays active (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  unsigned binary value to display.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept; accept = in_valid & in_ready at a clk edge.
- done  out  1  one-cycle pulse when new digits reach the display registers.
- ovf  out  1  last accepted value >= 10^NUM_DIGITS.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank=1111111; dash=1111110.
- an  out  NUM_DIGITS  digit enables, active-low one-hot; an[0] is the least significant digit.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - in_ready=1, done=0, ovf=0, seg=1111111, an=all ones.
  - State IDLE; scan index 0; prescaler 0; display-valid flag 0.
- FSM IDLE:
  - On accept: capture in_data into the shift register and clear the BCD accumulator.
  - Bit counter = DATA_W; go to CONV; in_ready=0.
  - in_valid while in_ready=0 is ignored; it is not queued.
- FSM CONV, each cycle:
  - For every BCD nibble >=5, add 3.
  - Then shift {bcd, shreg} left by 1 and decrement the counter.
  - After DATA_W shifts, go to LOAD.
- FSM LOAD, one cycle:
  - Copy the low NUM_DIGITS nibbles to the display registers.
  - Set display-valid; compute ovf; pulse done; return to IDLE with in_ready=1.
- Accumulator sizing and overflow:
  - The accumulator holds ceil(DATA_W*0.302)+1 digits (localparam), so no intermediate value is ever truncated.
  - ovf=1 iff any accumulator nibble at index >= NUM_DIGITS is nonzero.
  - When ovf=1, every digit shows dash.
- Latency:
  - Accept at edge k. done=1 and the new display registers take effect during the cycle after edge k+DATA_W+1.
  - in_ready returns to 1 on that same edge.
  - Throughput: one value per DATA_W+2 cycles.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously from reset, independent of the FSM.
  - At terminal count it wraps to 0 and the scan index advances modulo NUM_DIGITS (index NUM_DIGITS-1 wraps to 0).
  - seg and an are registered and track the scan index with exactly one cycle of lag.
  - While display-valid=0, an stays all ones and seg=1111111.
- Update timing:
  - A display update during scanning takes effect on the next seg register update.
  - There is no scan restart and no glitch to an.
- Nibble values 10-15 never occur in display registers. The decoder must still map them to blank so that no latch is inferred.
- If rst_n asserts mid-conversion, the partial result is discarded and the display returns to blank.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN.
- Defined: leading-zero blanking. Any digit above the most significant nonzero digit shows blank. Digit 0 always shows its value, so a value of 0 shows "0". Ovf dashes are unaffected.
- Undefined: every digit shows its value, including leading zeros.

Test Plan:
1. DATA_W=8, NUM_DIGITS=3. Accept 255 at edge k -> done pulse one cycle after edge k+9; digits 2,5,5; seg for an=110 is 0100100, for an=101 is 0100100, for an=011 is 0010010; ovf=0.
2. Value 7, macro undefined -> 0000001, 0000001, 0001111 on an[2], an[1], an[0]. Macro defined -> 1111111, 1111111, 0001111. Value 0 with macro defined -> an[0] shows 0000001.
3. NUM_DIGITS=2, value 150 -> ovf=1; both digits show 1111110. Next value 42 -> ovf=0; digits show 4 and 2.
4. Accept 255, then hold in_valid=1 with 99 during CONV -> 99 is not accepted; display shows 255. 99 is accepted on the first cycle in_ready=1 and appears after a further DATA_W+2 cycles.
5. SCAN_DIV=4, NUM_DIGITS=3 -> an sequence 110, 101, 011, 110, each held exactly 4 cycles. Before the first conversion, an=111 and seg=1111111.
6. rst_n low at CONV cycle 3 -> immediate in_ready=1, done=0, seg=1111111, an=111. A fresh accept of 9 after release displays 9 correctly.
